// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sample width, complex sample type and
// the delay-depth clamp used by the delay lines and the stage controller.
package fft_pkg;

  localparam int unsigned FFT_DATA_W = 19;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } cplx_t;

  // A depth of zero is meaningless for a delay line, so it becomes 1.
  function automatic int unsigned clamp_depth(input int unsigned req,
                                              input int unsigned max_depth);
    if (req == 0)
      return 1;
    if (req > max_depth)
      return max_depth;
    return req;
  endfunction

endpackage

// File: rtl/sdf_dl_mem.sv
// Register array for the SDF delay line: one synchronous write port and
// one asynchronous read port, kept separate so a RAM macro can replace it.
module sdf_dl_mem #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen)
      mem[waddr] <= wdata;
  end

  // Read-before-write: the read sees pre-edge contents even when raddr == waddr.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sdf_delay_line.sv
// Runtime-programmable complex delay line for SDF FFT stages: circular
// buffer with a fill tracker that gates the output to zero until primed.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W    = FFT_DATA_W,
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned PTR_W     = $clog2(MAX_DEPTH),
  parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_ld,
  input  logic [DEPTH_W-1:0] cfg_depth,
  input  logic [DATA_W-1:0]  in_r,
  input  logic [DATA_W-1:0]  in_i,
  output logic [DATA_W-1:0]  out_r,
  output logic [DATA_W-1:0]  out_i,
  output logic               out_vld,
  output logic [DEPTH_W-1:0] fill
);

  logic [PTR_W-1:0]    wptr;
  logic [DEPTH_W-1:0]  fill_cnt;
  logic [DEPTH_W-1:0]  depth_reg;
  logic [PTR_W-1:0]    waddr;
  logic [PTR_W-1:0]    raddr;
  logic                wen;
  logic [2*DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      fill_cnt  <= '0;
      depth_reg <= DEPTH_W'(MAX_DEPTH);
    end else if (cfg_ld) begin
      depth_reg <= DEPTH_W'(clamp_depth(32'(cfg_depth), MAX_DEPTH));
      // A sample accepted on the flush edge is slot 0 of the new configuration.
      if (en) begin
        wptr     <= PTR_W'(1);
        fill_cnt <= DEPTH_W'(1);
      end else begin
        wptr     <= '0;
        fill_cnt <= '0;
      end
    end else if (en) begin
      wptr <= wptr + PTR_W'(1);
      if (fill_cnt != DEPTH_W'(MAX_DEPTH))
        fill_cnt <= fill_cnt + DEPTH_W'(1);
    end
  end

  assign wen   = en & ~rst;
  assign waddr = cfg_ld ? '0 : wptr;
  // MAX_DEPTH is a power of two, so the PTR_W-bit wrap is the modulo.
  assign raddr = wptr - PTR_W'(depth_reg);

  sdf_dl_mem #(
    .WIDTH (2 * DATA_W),
    .DEPTH (MAX_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .wen   (wen),
    .waddr (waddr),
    .wdata ({in_r, in_i}),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    out_vld = (fill_cnt >= depth_reg);
    out_r   = '0;
    out_i   = '0;
    if (out_vld) begin
      out_r = rdata[2*DATA_W-1:DATA_W];
      out_i = rdata[DATA_W-1:0];
    end
  end

  assign fill = fill_cnt;

endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line: vector table for the streaming cases,
// hand-written sequences for flush, stall, clamp and reset corner cases.
module tb_sdf_delay_line;

  localparam int unsigned DW = 19;
  localparam int unsigned FW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_ld = 1'b0;
  logic [FW-1:0] cfg_depth = '0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          out_vld;
  logic [FW-1:0] fill;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          en;
    logic          ld;
    logic [FW-1:0] depth;
    logic [DW-1:0] ir;
    logic [DW-1:0] ii;
    logic [DW-1:0] er;
    logic [DW-1:0] ei;
    logic          ev;
    logic [FW-1:0] ef;
  } vec_t;

  vec_t tbl[$];

  sdf_delay_line #(
    .DATA_W    (DW),
    .MAX_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_ld    (cfg_ld),
    .cfg_depth (cfg_depth),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_vld   (out_vld),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l,
                       input logic [FW-1:0] d, input logic [DW-1:0] ir,
                       input logic [DW-1:0] ii);
    rst = r; en = e; cfg_ld = l; cfg_depth = d; in_r = ir; in_i = ii;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [DW-1:0] er,
                            input logic [DW-1:0] ei, input logic ev,
                            input logic [FW-1:0] ef);
    chk({nm, ".out_r"}, 64'(out_r), 64'(er));
    chk({nm, ".out_i"}, 64'(out_i), 64'(ei));
    chk({nm, ".out_vld"}, 64'(out_vld), 64'(ev));
    chk({nm, ".fill"}, 64'(fill), 64'(ef));
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic l,
                              input logic [FW-1:0] d, input logic [DW-1:0] ir,
                              input logic [DW-1:0] ii, input logic [DW-1:0] er,
                              input logic [DW-1:0] ei, input logic ev,
                              input logic [FW-1:0] ef);
    vec_t v;
    v.rst = r; v.en = e; v.ld = l; v.depth = d; v.ir = ir; v.ii = ii;
    v.er = er; v.ei = ei; v.ev = ev; v.ef = ef;
    return v;
  endfunction

  logic [2*DW-1:0] sr[4];
  int              cnt;
  logic [DW-1:0]   dr, di;
  logic [2*DW-1:0] expd;

  initial begin
    // Reset, then default depth 16: output of edge n is input n-15.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 1; n <= 40; n++) begin
      if (n >= 16)
        tbl.push_back(mk(0, 1, 0, 0, DW'(n), DW'(-n), DW'(n - 15), DW'(-(n - 15)),
                         1, FW'(16)));
      else
        tbl.push_back(mk(0, 1, 0, 0, DW'(n), DW'(-n), 0, 0, 0, FW'(n)));
    end
    // Flush to depth 8 with en low, then stream 100..: first valid is 100.
    tbl.push_back(mk(0, 0, 1, FW'(8), 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 20; i++) begin
      if (i >= 8)
        tbl.push_back(mk(0, 1, 0, 0, DW'(99 + i), ~DW'(99 + i), DW'(100 + i - 8),
                         ~DW'(100 + i - 8), 1, FW'(i > 16 ? 16 : i)));
      else
        tbl.push_back(mk(0, 1, 0, 0, DW'(99 + i), ~DW'(99 + i), 0, 0, 0, FW'(i)));
    end

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].ld, tbl[k].depth, tbl[k].ir, tbl[k].ii);
      expect_out($sformatf("vec%0d", k), tbl[k].er, tbl[k].ei, tbl[k].ev, tbl[k].ef);
    end

    // Depth 4 with en pattern 1,0,0,1: compare with an en-gated shift register.
    drive(0, 0, 1, FW'(4), 0, 0);
    expect_out("d4_flush", 0, 0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      automatic logic e = ((c % 4) == 0) || ((c % 4) == 3);
      dr = DW'($urandom);
      di = DW'($urandom);
      drive(0, e, 0, 0, dr, di);
      if (e) begin
        for (int s = 3; s > 0; s--) sr[s] = sr[s-1];
        sr[0] = {dr, di};
        if (cnt < 16) cnt++;
      end
      expd = (cnt >= 4) ? sr[3] : '0;
      expect_out($sformatf("d4_c%0d", c), expd[2*DW-1:DW], expd[DW-1:0],
                 cnt >= 4, FW'(cnt));
    end

    // cfg_ld and en on the same edge: that sample is the first of the new depth.
    drive(0, 1, 1, FW'(2), DW'(7), DW'(70));
    expect_out("ld_en_first", 0, 0, 0, FW'(1));
    drive(0, 1, 0, 0, DW'(8), DW'(80));
    expect_out("ld_en_second", DW'(7), DW'(70), 1, FW'(2));

    // cfg_depth=0 acts as depth 1: next-cycle echo.
    drive(0, 1, 1, FW'(0), DW'(5), DW'(50));
    expect_out("d0_first", DW'(5), DW'(50), 1, FW'(1));
    drive(0, 1, 0, 0, DW'(6), DW'(60));
    expect_out("d0_echo", DW'(6), DW'(60), 1, FW'(2));
    drive(0, 0, 0, 0, DW'(9), DW'(90));
    expect_out("d0_stall", DW'(6), DW'(60), 1, FW'(2));

    // cfg_depth=31 clamps to 16.
    drive(0, 0, 1, FW'(31), 0, 0);
    expect_out("d31_flush", 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 0, DW'(300 + i), DW'(400 + i));
      if (i == 15) expect_out("d31_not_yet", 0, 0, 0, FW'(15));
      if (i == 16) expect_out("d31_first", DW'(301), DW'(401), 1, FW'(16));
    end

    // Reset mid-stream at fill=10; stale data must never appear on refill.
    drive(0, 0, 1, FW'(16), 0, 0);
    for (int i = 1; i <= 10; i++) drive(0, 1, 0, 0, DW'(500 + i), DW'(600 + i));
    expect_out("pre_rst", 0, 0, 0, FW'(10));
    drive(1, 1, 0, 0, DW'(777), DW'(777));
    expect_out("rst_mid", 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      drive(0, 1, 0, 0, DW'(200 + i), DW'(250 + i));
      if (i >= 16)
        expect_out($sformatf("refill%0d", i), DW'(200 + i - 15), DW'(250 + i - 15),
                   1, FW'(16));
      else
        expect_out($sformatf("refill%0d", i), 0, 0, 0, FW'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sdf_delay_line.md
Name: sdf_delay_line

Overview:
- Parametrised, runtime-reconfigurable complex delay line for the single-path delay-feedback (SDF) butterfly stages of the FFT datapath.
- Replaces the fixed-length per-stage shift registers. One block serves any stage or FFT size: the delay is programmed at runtime.
- Supports pipeline stalls through an enable input and flushing.
- Built as a circular buffer with a fill tracker. The output is forced to zero until the line is primed.

Parameters:
- DATA_W, 19, width of each real and imaginary component.
- MAX_DEPTH, 16, largest supported delay in enabled cycles; power of two, at least 2.
- PTR_W, $clog2(MAX_DEPTH), width of the write and read pointers (derived).
- DEPTH_W, $clog2(MAX_DEPTH+1), width of the depth and fill fields (derived).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  advance the line; the sample on in_r/in_i is accepted when high.
- cfg_ld  input  1  load cfg_depth and flush the line.
- cfg_depth  input  DEPTH_W  requested delay; sampled only when cfg_ld=1.
- in_r  input  DATA_W  real input sample.
- in_i  input  DATA_W  imaginary input sample.
- out_r  output  DATA_W  real delayed sample.
- out_i  output  DATA_W  imaginary delayed sample.
- out_vld  output  1  high when the line holds at least depth accepted samples.
- fill  output  DEPTH_W  number of accepted samples since the last flush, saturating at MAX_DEPTH.

Behaviour:
- State:
  - mem[MAX_DEPTH] complex entries.
  - wptr (PTR_W).
  - fill_cnt (DEPTH_W).
  - depth_reg (DEPTH_W).
- Reset (rst=1 at a rising edge; overrides everything):
  - wptr=0, fill_cnt=0, depth_reg=MAX_DEPTH.
  - mem is not cleared.
  - Outputs after reset: out_r=0, out_i=0, out_vld=0, fill=0.
- Priority per edge: rst > cfg_ld > en.
- cfg_ld=1:
  - depth_reg <= clamp(cfg_depth). Value 0 becomes 1; values above MAX_DEPTH become MAX_DEPTH.
  - wptr <= 0 and fill_cnt <= 0.
  - If en=1 on the same edge, that input is the first sample of the new configuration: mem[0] written, wptr <= 1, fill_cnt <= 1.
- en=1 without cfg_ld:
  - mem[wptr] <= {in_r, in_i}.
  - wptr <= wptr+1, wrapping modulo MAX_DEPTH.
  - fill_cnt <= min(fill_cnt+1, MAX_DEPTH).
- en=0 without cfg_ld or rst: all state holds and outputs are stable (stall).
- Read path (combinational from registered state):
  - raddr = (wptr - depth_reg) mod MAX_DEPTH.
  - out_vld = (fill_cnt >= depth_reg).
  - out_r/out_i = out_vld ? mem[raddr] : 0.
- Latency:
  - With en held high, out presented before edge k equals the input accepted at edge k-depth_reg.
  - For depth D this is identical to a D-stage flop shift register clocked by en.
- Width rules:
  - No arithmetic on data; samples pass bit-exact.
  - Pointer subtraction is done modulo 2^PTR_W; MAX_DEPTH being a power of two makes this exact.
- Boundary conditions:
  - depth_reg = MAX_DEPTH: raddr equals wptr, so the oldest entry is read while the same slot is being overwritten. The read is pre-edge data (read-before-write).
  - Full line: fill saturates at MAX_DEPTH and never wraps.
  - Reset or cfg_ld mid-stream: stale mem contents are never visible, because out_vld gates the data to zero until refilled.
  - cfg_ld with en=0: flush only; outputs are zero from the next cycle.

Decomposition:
- Package fft_pkg holds:
  - DATA_W default (19).
  - A complex sample typedef {re, im}.
  - A depth-clamp function shared with the stage controller.
- One natural sub-module: sdf_dl_mem, the MAX_DEPTH x 2*DATA_W register array with one write port and one asynchronous read port. This allows later swap to a RAM macro.
- Pointer, fill and configuration logic stay in the top module.

Test Plan:
- Reset then default depth 16, en=1, inputs re=n, im=-n for n=1..40 -> out zero and out_vld=0 for the first 16 edges; then out re=1, im=-1 and so on; fill saturates at 16.
- cfg_ld with depth 8 (en=0), then stream n=100.. -> first valid output is re=100 after 8 enables; matches an 8-flop reference model bit-exactly.
- Depth 4, en toggling 1,0,0,1,... with random data -> output advances only on enabled edges; values held across stalls; scoreboard matches an en-gated model.
- cfg_ld and en on the same edge with depth 2, in re=7 -> fill=1 and out_vld=0 next cycle; one more enable gives out re=7 and out_vld=1.
- cfg_depth=0 gives effective depth 1 (next-cycle echo); cfg_depth=31 clamps to 16.
- rst asserted mid-stream at fill=10 -> next cycle out=0, out_vld=0, fill=0, depth_reg=16; no stale data after the refill completes.
